bin2bcd_encoder: RTL
====================

Name: bin2bcd_encoder

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble).
- Produces the packed 4-bit BCD digits that feed the seven-segment decoder instances, one nibble per display digit.
- Sits between datapath/bus-facing registers (counters, addresses, data words) and the display decoders.
- Start/busy/done handshake; one bit is processed per clock.

Parameters:
- WIDTH, 16, binary input width in bits (>=4).
- DIGITS, 5, number of BCD output digits; the default covers 0..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled only when busy=0.
- bin  input  WIDTH  unsigned binary value; captured on the accepting edge.
- busy  output  1  high from the accepting edge until the edge after done.
- done  output  1  one-cycle pulse; bcd and overflow are valid from this cycle onward.
- bcd  output  4*DIGITS  packed result; digit 0 (units) is at [3:0], most significant digit at the top.
- overflow  output  1  high when bin >= 10^DIGITS; registered with bcd.
- blank  output  DIGITS  leading-zero blank mask; see Optional Feature.

Behaviour:
Reset (rstn low, asynchronous):
- state=IDLE; busy=0, done=0, bcd=0, overflow=0, blank=0.
- Internal shift register, scratch and counter are cleared.
- Reset asserted mid-conversion aborts it: no done pulse, and bcd is not updated with partial data.

State machine IDLE -> CONVERT -> DONE -> IDLE:
- IDLE: busy=0, done=0. A clock edge with start=1:
  - loads shift register <= bin, scratch <= 0, cnt <= 0, sticky ovf <= 0;
  - moves to CONVERT.
- CONVERT: busy=1. Each edge:
  - every scratch digit >=5 gets +3 (4-bit, no carry between digits);
  - the concatenation {scratch, shift} shifts left by 1;
  - the bit shifted out of the scratch MSB is ORed into sticky ovf;
  - cnt increments.
- Leaving CONVERT: on the edge where cnt==WIDTH-1 the last shift is performed and the FSM moves to DONE. The same edge loads:
  - bcd <= final scratch;
  - overflow <= sticky ovf;
  - blank <= computed mask.
- DONE: busy=1, done=1 for exactly one cycle; the next edge returns to IDLE.

Timing and throughput:
- Latency: done is high in the cycle beginning WIDTH edges after the accepting edge (16 cycles at the default).
- Throughput: one conversion per WIDTH+2 cycles.

Input and output rules:
- start while busy=1 (CONVERT or DONE) is ignored. It is not queued.
- bin changes after the accepting edge have no effect.
- bcd, overflow and blank hold their last value until the next DONE and never show intermediate values.

Overflow:
- When overflow=1, bcd holds the low DIGITS decimal digits of bin mod 10^DIGITS. This is a natural consequence of the algorithm.
- Each output digit is always in 0..9.

Optional Feature:
Macro: BIN2BCD_BLANK_EN
- Defined:
  - blank[i]=1 when digit i and every digit above it are zero.
  - blank[0] is always 0, so a zero value still displays "0".
  - blank is forced to 0 when overflow=1.
  - blank is registered alongside bcd.
- Undefined:
  - blank port is still present but tied to all-zero.
  - No mask logic is synthesized.

Decomposition:
- Shared include bin2bcd_defs.vh holds:
  - state encodings S_IDLE=2'd0, S_CONVERT=2'd1, S_DONE=2'd2;
  - BCD_ADJ_THRESH=4'd5 and BCD_ADJ_ADD=4'd3.
- One sub-module: bcd_adjust_digit. It is combinational, 4-bit in / 4-bit out, adding 3 when the input is >=5. The top level instantiates it DIGITS times via generate.
- FSM, counter, shift registers and the blank mask stay in the top level.

Test Plan:
1. Defaults. Reset, then start with bin=16'd0 -> done exactly 16 cycles after the accepting edge; bcd=20'h00000, overflow=0; blank=5'b11110 with macro, 0 without.
2. bin=16'd65535 -> bcd=20'h65535, overflow=0, blank=5'b00000. Also bin=16'd1234 -> bcd=20'h01234, blank=5'b10000 with macro.
3. Start with bin=16'd42; pulse start with bin=16'd999 at cycles 3 and 16 (during DONE) -> single done, bcd=20'h00042, busy never drops early. A start at the first IDLE cycle afterwards is accepted.
4. Start with bin=16'd500; hold rstn low at cycle 8 -> busy, done, bcd, overflow drop to 0 immediately with no done pulse. After release, start with bin=16'd7 -> bcd=20'h00007.
5. WIDTH=10, DIGITS=3, bin=10'd1000 -> overflow=1, bcd=12'h000, blank=0. bin=10'd999 -> overflow=0, bcd=12'h999.
6. Back-to-back: random 1000 values, start asserted every cycle -> every done result matches the reference model; done spacing is exactly WIDTH+2 cycles.

Source files
------------

// File: rtl/bin2bcd_encoder_pkg.sv
// Shared definitions for the binary-to-BCD encoder: FSM state encodings and
// the shift-add-3 digit adjustment constants.
package bin2bcd_encoder_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_adjust_digit.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_adjust_digit
  import bin2bcd_encoder_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= BCD_ADJ_THRESH) ? (din + BCD_ADJ_ADD) : din;

endmodule

// File: rtl/bin2bcd_encoder.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, start/busy/done.
// Optional leading-zero blank mask is enabled with BIN2BCD_BLANK_EN.
module bin2bcd_encoder
  import bin2bcd_encoder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    scratch_nxt;
  logic [CW-1:0]    cnt;
  logic             ovf_sticky;
  logic             ovf_nxt;
  logic             last_bit;
  logic             accept;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adjust_digit u_adj (
      .din  (scratch[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // Bit leaving the top digit after adjustment is a decimal carry out of range.
  assign scratch_nxt = {adj[BW-2:0], shift_reg[WIDTH-1]};
  assign ovf_nxt     = ovf_sticky | adj[BW-1];
  assign last_bit    = (cnt == CW'(WIDTH - 1));
  assign accept      = (state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_reg  <= '0;
      scratch    <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
    end else if (accept) begin
      shift_reg  <= bin;
      scratch    <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
    end else if (state == S_CONVERT) begin
      shift_reg  <= {shift_reg[WIDTH-2:0], 1'b0};
      scratch    <= scratch_nxt;
      ovf_sticky <= ovf_nxt;
      cnt        <= cnt + CW'(1);
    end
  end

  // Results update only on the final shift, so partial values never appear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcd      <= '0;
      overflow <= 1'b0;
    end else if ((state == S_CONVERT) && last_bit) begin
      bcd      <= scratch_nxt;
      overflow <= ovf_nxt;
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_mask;
  logic [DIGITS-1:0] blank_q;
  logic              zero_run;

  // Walk down from the top digit; the units digit is never blanked.
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (scratch_nxt[4*i +: 4] == 4'd0);
      blank_mask[i] = zero_run & ~ovf_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blank_q <= '0;
    end else if ((state == S_CONVERT) && last_bit) begin
      blank_q <= blank_mask;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule
